// File: rtl/seq_multiplier_if.sv
// Request/response bundle for the sequential multiplier.
// The issue stage drives the master side.
interface seq_multiplier_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, op, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied, then the sign is applied in FIXUP.
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   res_q;

  logic              s1;
  logic              s2;
  logic [XLEN-1:0]   abs1;
  logic [XLEN-1:0]   abs2;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod;
  logic              last;

  // Operand signs, magnitudes, step adder and signed product.
  always_comb begin
    s1   = bus.rs1[XLEN-1] &
           ((bus.op == 2'b01) | (bus.op == 2'b10));
    s2   = bus.rs2[XLEN-1] & (bus.op == 2'b01);
    abs1 = s1 ? -bus.rs1 : bus.rs1;
    abs2 = s2 ? -bus.rs2 : bus.rs2;
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    prod = neg_q ? -acc : acc;
    last = (cnt == '1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush wins over everything.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (bus.start) state_nxt = CALC;
        CALC:  if (last) state_nxt = FIXUP;
        FIXUP: state_nxt = DONE;
        DONE:  state_nxt = IDLE;
      endcase
    end
  end

  // Operand latch, shift-add datapath and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= 2'b00;
      neg_q  <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      res_q  <= '0;
    end else if (!bus.flush) begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            neg_q  <= s1 ^ s2;
            mcand  <= abs1;
            mplier <= abs2;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= {sum, acc[XLEN-1:1]};
          end else begin
            acc <= {1'b0, acc[2*XLEN-1:1]};
          end
          mplier <= {1'b0, mplier[XLEN-1:1]};
          cnt    <= cnt + 1'b1;
        end
        FIXUP: begin
          acc <= prod;
          if (op_q == 2'b00) begin
            res_q <= prod[XLEN-1:0];
          end else begin
            res_q <= prod[2*XLEN-1:XLEN];
          end
        end
        DONE: begin
        end
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = res_q;
endmodule
